// File: rtl/inv_addkey_pkg.sv
// inv_addkey_pkg: shared AES-128 constants, S-box lookup and FSM encoding
// for the inverse AddRoundKey block.
package inv_addkey_pkg;
    localparam int NR = 10;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] READY  = 2'd2;
    // Padded to 16 entries so every step-counter value indexes a defined byte.
    localparam logic [0:15][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction
    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction
endpackage

// File: rtl/inv_addkey_if.sv
// inv_addkey_if: key-load and state-word handshake between the inverse
// mix-column stage and the inverse AddRoundKey block.
interface inv_addkey_if;
    logic [127:0] key;
    logic         key_load;
    logic [127:0] data_in;
    logic         in_valid;
    logic [3:0]   round;
    logic [127:0] data_out;
    logic         out_valid;
    logic         key_ready;
    logic         err;
    modport master (
        output key, key_load, data_in, in_valid, round,
        input  data_out, out_valid, key_ready, err
    );
    modport slave (
        input  key, key_load, data_in, in_valid, round,
        output data_out, out_valid, key_ready, err
    );
endinterface

// File: rtl/inv_addkey_key_step.sv
// key_step: one FIPS-197 AES-128 key-schedule step (RotWord, SubWord,
// Rcon, XOR chain) from the previous round key.
module key_step
    import inv_addkey_pkg::*;
(
    input  logic [127:0] prev,
    input  logic [7:0]   rcon,
    output logic [127:0] next
);
    logic [31:0] t, n0, n1, n2, n3;
    assign t  = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
    assign n0 = prev[127:96] ^ t;
    assign n1 = prev[95:64] ^ n0;
    assign n2 = prev[63:32] ^ n1;
    assign n3 = prev[31:0] ^ n2;
    assign next = {n0, n1, n2, n3};
endmodule

// File: rtl/inv_addkey.sv
// inv_addkey: AES-128 decryption AddRoundKey; expands the cipher key into
// a round-key store one key per cycle, then XORs beats with rk[NR-round].
module inv_addkey #(
    parameter int NR = inv_addkey_pkg::NR
) (
    input logic         clk,
    input logic         rst_n,
    inv_addkey_if.slave bus
);
    import inv_addkey_pkg::*;
    localparam int IW = $clog2(NR + 1);
    localparam int SW = $clog2(NR + 2);
    logic [1:0]    state;
    logic [SW-1:0] step;
    logic [127:0]  rk [0:NR];
    logic [127:0]  next_rk;
    logic          accept;
    key_step u_key_step (
        .prev (rk[IW'(step - SW'(1))]),
        .rcon (RCON[4'(step)]),
        .next (next_rk)
    );
    assign accept        = bus.in_valid && state == READY && bus.round <= 4'(NR);
    assign bus.key_ready = state == READY;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            step  <= '0;
        end else if (bus.key_load) begin
            state <= EXPAND;
            step  <= SW'(1);
        end else if (state == EXPAND) begin
            step  <= step + SW'(1);
            state <= step == SW'(NR) ? READY : EXPAND;
        end
    end
    // The store keeps its contents through reset; key_ready gates its use.
    always_ff @(posedge clk) begin
        if (rst_n && bus.key_load) rk[0] <= bus.key;
        else if (rst_n && state == EXPAND) rk[IW'(step)] <= next_rk;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.err       <= 1'b0;
            bus.data_out  <= '0;
        end else begin
            bus.out_valid <= accept;
            bus.err       <= bus.in_valid && !accept;
            if (accept) bus.data_out <= bus.data_in ^ rk[IW'(4'(NR) - bus.round)];
        end
    end
endmodule
